// File: rtl/sr_cmd_debounce.sv
// Command front end for the clocked S-R flip-flop: synchronizes and debounces two raw buttons,
// never drives S and R together. Define SR_PULSE_EN for single-cycle S/R pulses instead of levels.
module sr_cmd_debounce #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_rst,
    output logic S,
    output logic R,
    output logic conflict
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SET   = 2'd1,
        ST_RESET = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             sync1_set_r, sync_set_r;
    logic             sync1_rst_r, sync_rst_r;
    logic             deb_set_r, deb_rst_r;
    logic [CNT_W-1:0] cnt_set_r, cnt_rst_r;
    state_t           state_r, state_s;
    logic             s_r, r_r, conflict_r;
    logic             s_nxt_s, r_nxt_s, conflict_nxt_s;

    // Two-flop synchronizers for both raw buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_set_r <= 1'b0;
            sync_set_r  <= 1'b0;
            sync1_rst_r <= 1'b0;
            sync_rst_r  <= 1'b0;
        end else begin
            sync1_set_r <= btn_set;
            sync_set_r  <= sync1_set_r;
            sync1_rst_r <= btn_rst;
            sync_rst_r  <= sync1_rst_r;
        end
    end

    // Set-channel debounce: the counter only runs while the input disagrees with the stable value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_set_r <= 1'b0;
            cnt_set_r <= CNT_ZERO;
        end else if (sync_set_r == deb_set_r) begin
            cnt_set_r <= CNT_ZERO;
        end else if (cnt_set_r == CNT_LAST) begin
            deb_set_r <= sync_set_r;
            cnt_set_r <= CNT_ZERO;
        end else begin
            cnt_set_r <= cnt_set_r + CNT_ONE;
        end
    end

    // Reset-channel debounce, identical to the set channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_rst_r <= 1'b0;
            cnt_rst_r <= CNT_ZERO;
        end else if (sync_rst_r == deb_rst_r) begin
            cnt_rst_r <= CNT_ZERO;
        end else if (cnt_rst_r == CNT_LAST) begin
            deb_rst_r <= sync_rst_r;
            cnt_rst_r <= CNT_ZERO;
        end else begin
            cnt_rst_r <= cnt_rst_r + CNT_ONE;
        end
    end

    // Next-state logic; a release of the owning button always wins over a new press of the other
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (deb_set_r && deb_rst_r) begin
                    state_s = ST_LOCK;
                end else if (deb_set_r) begin
                    state_s = ST_SET;
                end else if (deb_rst_r) begin
                    state_s = ST_RESET;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SET: begin
                if (!deb_set_r) begin
                    state_s = ST_IDLE;
                end else if (deb_rst_r) begin
                    state_s = ST_LOCK;
                end else begin
                    state_s = ST_SET;
                end
            end
            ST_RESET: begin
                if (!deb_rst_r) begin
                    state_s = ST_IDLE;
                end else if (deb_set_r) begin
                    state_s = ST_LOCK;
                end else begin
                    state_s = ST_RESET;
                end
            end
            ST_LOCK: begin
                if (!deb_set_r && !deb_rst_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LOCK;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so outputs change on the same edge as the state
    always_comb begin
        s_nxt_s        = 1'b0;
        r_nxt_s        = 1'b0;
        conflict_nxt_s = (state_s == ST_LOCK);
`ifdef SR_PULSE_EN
        if (state_r == ST_IDLE) begin
            s_nxt_s = (state_s == ST_SET);
            r_nxt_s = (state_s == ST_RESET);
        end else begin
            s_nxt_s = 1'b0;
            r_nxt_s = 1'b0;
        end
`else
        s_nxt_s = (state_s == ST_SET);
        r_nxt_s = (state_s == ST_RESET);
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            s_r        <= 1'b0;
            r_r        <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            s_r        <= s_nxt_s;
            r_r        <= r_nxt_s;
            conflict_r <= conflict_nxt_s;
        end
    end

    assign S        = s_r;
    assign R        = r_r;
    assign conflict = conflict_r;

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Directed bench for sr_cmd_debounce at DEB_CYCLES=4; expectations follow SR_PULSE_EN when defined.
module tb_sr_cmd_debounce;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_set = 1'b0;
    logic btn_rst = 1'b0;
    logic S, R, conflict;
    int   n_checks = 0;
    int   n_errors = 0;
    logic seen_s;

`ifdef SR_PULSE_EN
    localparam logic LVL = 1'b0;
`else
    localparam logic LVL = 1'b1;
`endif

    sr_cmd_debounce #(.DEB_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_rst(btn_rst),
        .S(S), .R(R), .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // S and R must never be high together
    always @(negedge clk) begin
        chk("s_and_r_excl", {31'd0, S & R}, 32'd0);
    end

    initial begin
        // Reset held with both buttons pressed
        btn_set = 1'b1; btn_rst = 1'b1;
        tick(3);
        chk("rst_S", {31'd0, S}, 32'd0);
        chk("rst_R", {31'd0, R}, 32'd0);
        chk("rst_conflict", {31'd0, conflict}, 32'd0);
        rst_n = 1'b1;
        tick(6);
        chk("post_rst_conflict_e6", {31'd0, conflict}, 32'd0);
        chk("post_rst_S_e6", {31'd0, S}, 32'd0);
        tick(1);
        chk("post_rst_conflict_e7", {31'd0, conflict}, 32'd1);
        chk("post_rst_R_e7", {31'd0, R}, 32'd0);
        btn_set = 1'b0; btn_rst = 1'b0;
        tick(6);
        chk("lock_rel_e6", {31'd0, conflict}, 32'd1);
        tick(1);
        chk("lock_rel_e7", {31'd0, conflict}, 32'd0);
        tick(3);

        // Set press, held 20 cycles
        btn_set = 1'b1;
        tick(6);
        chk("set_S_e6", {31'd0, S}, 32'd0);
        tick(1);
        chk("set_S_e7", {31'd0, S}, 32'd1);
        chk("set_R_e7", {31'd0, R}, 32'd0);
        tick(1);
        chk("set_S_e8", {31'd0, S}, {31'd0, LVL});
        tick(12);
        chk("set_S_e20", {31'd0, S}, {31'd0, LVL});
        btn_set = 1'b0;
        tick(6);
        chk("set_rel_S_e6", {31'd0, S}, {31'd0, LVL});
        tick(1);
        chk("set_rel_S_e7", {31'd0, S}, 32'd0);
        tick(3);

        // Reset press (symmetric channel)
        btn_rst = 1'b1;
        tick(7);
        chk("rstbtn_R_e7", {31'd0, R}, 32'd1);
        chk("rstbtn_S_e7", {31'd0, S}, 32'd0);
        btn_rst = 1'b0;
        tick(10);
        chk("rstbtn_rel_R", {31'd0, R}, 32'd0);

        // Three-cycle glitch is rejected
        btn_set = 1'b1;
        tick(3);
        btn_set = 1'b0;
        seen_s = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            seen_s = seen_s | S;
        end
        chk("glitch_S_seen", {31'd0, seen_s}, 32'd0);
        chk("glitch_deb_set", {31'd0, dut.deb_set_r}, 32'd0);

        // Simultaneous press, then partial and full release
        btn_set = 1'b1; btn_rst = 1'b1;
        tick(6);
        chk("simul_conflict_e6", {31'd0, conflict}, 32'd0);
        tick(1);
        chk("simul_conflict_e7", {31'd0, conflict}, 32'd1);
        chk("simul_S", {31'd0, S}, 32'd0);
        chk("simul_R", {31'd0, R}, 32'd0);
        btn_set = 1'b0;
        tick(10);
        chk("partial_rel_conflict", {31'd0, conflict}, 32'd1);
        chk("partial_rel_R", {31'd0, R}, 32'd0);
        btn_rst = 1'b0;
        tick(6);
        chk("full_rel_e6", {31'd0, conflict}, 32'd1);
        tick(1);
        chk("full_rel_e7", {31'd0, conflict}, 32'd0);
        tick(3);

        // Staggered press: set, then reset 10 cycles later
        btn_set = 1'b1;
        tick(10);
        chk("stag_S_before", {31'd0, S}, {31'd0, LVL});
        btn_rst = 1'b1;
        tick(6);
        chk("stag_S_e6", {31'd0, S}, {31'd0, LVL});
        chk("stag_conflict_e6", {31'd0, conflict}, 32'd0);
        tick(1);
        chk("stag_S_e7", {31'd0, S}, 32'd0);
        chk("stag_conflict_e7", {31'd0, conflict}, 32'd1);
        btn_set = 1'b0; btn_rst = 1'b0;
        tick(7);
        chk("stag_rel_conflict", {31'd0, conflict}, 32'd0);
        tick(3);

        // Asynchronous reset while in SET, button still held
        btn_set = 1'b1;
        tick(7);
        chk("mid_S_before_rst", {31'd0, S}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_S_async_clear", {31'd0, S}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(6);
        chk("mid_reS_e6", {31'd0, S}, 32'd0);
        tick(1);
        chk("mid_reS_e7", {31'd0, S}, 32'd1);
        btn_set = 1'b0;
        tick(10);
        chk("final_S", {31'd0, S}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
